tmds_encoder: RTL

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_encoder_if.sv | 23 ++
 rtl/tmds_encoder_tm_choice.sv | 26 ++
 rtl/tmds_encoder.sv | 59 +++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared DVI 8b/10b definitions: control symbols, disparity type and small helpers
// used by the encoder, the serializer and bench models.
package tmds_pkg;

    typedef logic signed [4:0] disp_t;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    localparam disp_t DISP_ZERO = 5'sd0;
    localparam disp_t DISP_TWO  = 5'sd2;
    localparam disp_t DISP_BITS = 5'sd8;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            acc = acc + {3'b000, v[i]};
        end
        return acc;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] sym;
        case (c)
            2'b00:   sym = TMDS_CTRL_00;
            2'b01:   sym = TMDS_CTRL_01;
            2'b10:   sym = TMDS_CTRL_10;
            default: sym = TMDS_CTRL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Per-channel pixel bus into the TMDS encoder and the encoded symbol back out.
interface tmds_encoder_if;

    logic [7:0] data_in;
    logic [1:0] control_in;
    logic       ve_in;
    logic [9:0] tmds_out;

    modport master (
        output data_in,
        output control_in,
        output ve_in,
        input  tmds_out
    );

    modport slave (
        input  data_in,
        input  control_in,
        input  ve_in,
        output tmds_out
    );

endinterface

// File: rtl/tmds_encoder_tm_choice.sv
// Stage-1 transition minimisation: picks XOR or XNOR chaining to minimise edges.
module tm_choice
    import tmds_pkg::*;
(
    input  logic [7:0] data_in,
    output logic [8:0] q_m
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic       prev;

    always_comb begin
        n1d      = ones8(data_in);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_in[0]);
        q_m      = '0;
        prev     = data_in[0];
        q_m[0]   = data_in[0];
        for (int unsigned i = 1; i < 8; i++) begin
            prev   = use_xnor ? ~(prev ^ data_in[i]) : (prev ^ data_in[i]);
            q_m[i] = prev;
        end
        q_m[8] = ~use_xnor;
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS channel encoder: one-cycle registered 8b/10b symbol with running
// DC-balance tracking; control symbols during blanking.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic          clk_pixel_in,
    input  logic          rst_n_in,
    tmds_encoder_if.slave bus
);

    logic [8:0] q_m;
    disp_t      n1, n0, diff;
    logic [9:0] tmds_d, tmds_q;
    disp_t      cnt_d, cnt_q;

    tm_choice u_tm_choice (
        .data_in (bus.data_in),
        .q_m     (q_m)
    );

    always_comb begin
        n1   = {1'b0, ones8(q_m[7:0])};
        n0   = DISP_BITS - n1;
        diff = n1 - n0;
    end

    always_comb begin
        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (!bus.ve_in) begin
            tmds_d = ctrl_symbol(bus.control_in);
            cnt_d  = DISP_ZERO;
        end else if ((cnt_q == DISP_ZERO) || (n1 == n0)) begin
            tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_d  = q_m[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > DISP_ZERO) && (n1 > n0)) ||
                     ((cnt_q < DISP_ZERO) && (n0 > n1))) begin
            // Invert the payload to pull the running disparity back toward zero.
            tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_d  = cnt_q + (q_m[8] ? DISP_TWO : DISP_ZERO) - diff;
        end else begin
            tmds_d = {1'b0, q_m[8], q_m[7:0]};
            cnt_d  = cnt_q + diff - (q_m[8] ? DISP_ZERO : DISP_TWO);
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmds_q <= '0;
            cnt_q  <= DISP_ZERO;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.tmds_out = tmds_q;

endmodule
